var_delay_line: RTL and testbench
=================================

VAR_DELAY_LINE -- requirements
Module: var_delay_line

Interface
REQ-001 SHALL have parameter N, default 8, bit width of one channel.
REQ-002 SHALL have parameter CH, default 1, number of channels packed side by side; channel c occupies bits [c*N+N-1 : c*N].
REQ-003 SHALL have parameter MAX_DELAY, default 16, largest supported delay in enabled cycles; legal range 1..1024.
REQ-004 SHALL have parameter INIT_DELAY, default 1, delay value loaded at reset; legal range 0..MAX_DELAY.
REQ-005 SHALL define DW = clog2(MAX_DELAY+1).
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-008 SHALL have port ce, input, 1, clock enable; when low, all state holds.
REQ-009 SHALL have port flush, input, 1, clears all stored valid flags, effective when ce is high.
REQ-010 SHALL have port delay, input, DW, requested delay in enabled cycles.
REQ-011 SHALL have port in_valid, input, 1, qualifies data.
REQ-012 SHALL have port data, input, CH*N, input samples.
REQ-013 SHALL have port outp, output, CH*N, delayed samples.
REQ-014 SHALL have port out_valid, output, 1, qualifies outp.
REQ-015 SHALL have port delay_err, output, 1, sticky flag for an out-of-range delay request.

Function
REQ-016 SHALL store {in_valid, data} in a circular buffer of MAX_DELAY entries, indexed by write pointer wp, on every clk edge with ce=1; wp wraps from MAX_DELAY-1 to 0.
REQ-017 SHALL keep a registered effective delay d_q, loaded on ce=1 edges with min(delay, MAX_DELAY); the new d_q governs outputs from the following cycle.
REQ-018 SHALL, when d_q >= 1, drive outp/out_valid from the entry written d_q enabled cycles earlier, i.e. buffer index (wp - d_q) mod MAX_DELAY, with wrap-around.
REQ-019 SHALL, when d_q = 0, bypass combinationally: outp = data, out_valid = in_valid.
REQ-020 SHALL, when d_q >= 1, have no combinational path from data or in_valid to outputs.
REQ-021 SHALL drive outp to all-zero whenever out_valid = 0.
REQ-022 SHALL treat all channels identically with the same delay; there is no cross-channel interaction.
REQ-023 SHALL make a delay change take effect immediately, with no refill.
REQ-024 SHALL, on a delay decrease, pass over the skipped samples.
REQ-025 SHALL, on a delay increase, repeat already-output samples, marked valid only if their stored valid flag is set.
REQ-026 SHALL, when ce=0, hold wp, d_q, buffer and valid flags; outputs SHALL still follow the combinational selection, so they are stable unless the bypass input changes.
REQ-027 SHALL, on flush=1 with ce=1, clear every stored valid flag, including the entry written that cycle (stored with valid=0).
REQ-028 SHALL ignore flush when ce=0.
REQ-029 SHALL set delay_err on a ce=1 edge where delay > MAX_DELAY; it stays set until rst; clamping per REQ-017 still applies.
REQ-030 SHALL, with simultaneous flush and a delay change, apply both on the same edge.

Reset
REQ-031 SHALL, on rst=1 at a clk edge, regardless of ce: wp=0, d_q=INIT_DELAY, all stored valid flags=0, delay_err=0.
REQ-032 SHALL not require reset of the buffer data bits.
REQ-033 SHALL, after reset with INIT_DELAY >= 1, have out_valid=0 and outp=0 until valid samples reach the read index.
REQ-034 SHALL, when rst is asserted mid-stream, discard all in-flight samples; the first post-reset valid output appears exactly d_q enabled cycles after the first post-reset valid input.

Verification
REQ-035 SHALL cover fixed delay (N=8, CH=2, MAX_DELAY=16, delay=5, ce=1, in_valid=1, data incrementing 0x0100,0x0201,...) -> outp equals input of 5 cycles earlier; out_valid rises on cycle 5; both channels are correct.
REQ-036 SHALL cover ce gating: ce toggled 1,0,1,0 with delay=3 -> output advances only on ce=1 cycles; latency is 3 enabled cycles; no sample is lost or duplicated.
REQ-037 SHALL cover delay change in a steady stream at delay 8: switch to 2 -> next output is the sample 2 back, 6 samples skipped; switch back to 8 -> 6 samples repeated, out_valid=1.
REQ-038 SHALL cover bypass and clamp: delay=0 -> outp==data the same cycle; delay=20 -> effective 16, delay_err=1 and stays 1 after delay returns to 4, until rst.
REQ-039 SHALL cover flush: stream at delay 4, flush pulsed 1 cycle -> out_valid=0 and outp=0 for exactly 4 cycles after the flush edge (the flushed entry included), then valid resumes.
REQ-040 SHALL cover mid-stream reset: rst for 1 cycle during streaming at delay 6 -> out_valid=0 next cycle; d_q=INIT_DELAY; first valid output exactly INIT_DELAY enabled cycles after the first post-reset valid input.

Source files
------------

// File: rtl/var_delay_line.sv
// Variable-length delay line for CH packed channels of N bits each.
// A circular buffer of MAX_DELAY entries is read d_q enabled cycles behind the write pointer.
module var_delay_line #(
    parameter int N          = 8,
    parameter int CH         = 1,
    parameter int MAX_DELAY  = 16,
    parameter int INIT_DELAY = 1,
    localparam int DW        = $clog2(MAX_DELAY + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic            flush,
    input  logic [DW-1:0]   delay,
    input  logic            in_valid,
    input  logic [CH*N-1:0] data,
    output logic [CH*N-1:0] outp,
    output logic            out_valid,
    output logic            delay_err
);

    localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

    logic [CH*N-1:0]      mem_q [MAX_DELAY];
    logic [MAX_DELAY-1:0] vld_q, vld_d;
    logic [AW-1:0]        wp_q, wp_d;
    logic [DW-1:0]        d_q, d_d;
    logic                 err_q, err_d;
    logic [DW:0]          rd_sum;
    logic [AW-1:0]        rd_idx;
    logic                 sel_valid;
    logic [CH*N-1:0]      sel_data;
    logic                 too_big;

    assign too_big = (delay > DW'(MAX_DELAY));

    always_comb begin
        wp_d  = wp_q;
        d_d   = d_q;
        err_d = err_q;
        if (ce) begin
            wp_d  = (wp_q == AW'(MAX_DELAY - 1)) ? '0 : wp_q + 1'b1;
            d_d   = too_big ? DW'(MAX_DELAY) : delay;
            err_d = err_q | too_big;
        end
    end

    // The entry written on a flush edge is stored invalid along with all older ones.
    generate
        for (genvar gi = 0; gi < MAX_DELAY; gi++) begin : g_vld
            assign vld_d[gi] = !ce                 ? vld_q[gi] :
                               (wp_q == AW'(gi))   ? (in_valid & ~flush) :
                                                     (vld_q[gi] & ~flush);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            d_q   <= DW'(INIT_DELAY);
            vld_q <= '0;
            err_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            d_q   <= d_d;
            vld_q <= vld_d;
            err_q <= err_d;
        end
    end

    // Data bits need no reset: they are masked by the valid flags.
    always_ff @(posedge clk) begin
        if (ce) begin
            mem_q[wp_q] <= data;
        end
    end

    // (wp - d_q) mod MAX_DELAY, with d_q = MAX_DELAY selecting the oldest entry.
    assign rd_sum = (DW+1)'(wp_q) + (DW+1)'(MAX_DELAY) - (DW+1)'(d_q);
    assign rd_idx = (rd_sum >= (DW+1)'(MAX_DELAY)) ? AW'(rd_sum - (DW+1)'(MAX_DELAY))
                                                   : AW'(rd_sum);

    always_comb begin
        sel_valid = vld_q[rd_idx];
        sel_data  = mem_q[rd_idx];
        if (d_q == '0) begin
            sel_valid = in_valid;
            sel_data  = data;
        end
    end

    assign out_valid = sel_valid;
    assign outp      = sel_valid ? sel_data : '0;
    assign delay_err = err_q;

endmodule

// File: tb/tb_var_delay_line.sv
// Self-checking bench for var_delay_line: history-queue model compared every cycle,
// plus hand-computed expectations at key points of each directed scenario.
module tb_var_delay_line;

    localparam int N    = 8;
    localparam int CH   = 2;
    localparam int MAX  = 16;
    localparam int INIT = 1;
    localparam int DW   = $clog2(MAX + 1);

    logic            clk = 1'b0;
    logic            rst, ce, flush, in_valid;
    logic [DW-1:0]   delay;
    logic [CH*N-1:0] data, outp;
    logic            out_valid, delay_err;

    int cmp_cnt = 0;
    int err_cnt = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    var_delay_line #(.N(N), .CH(CH), .MAX_DELAY(MAX), .INIT_DELAY(INIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .flush     (flush),
        .delay     (delay),
        .in_valid  (in_valid),
        .data      (data),
        .outp      (outp),
        .out_valid (out_valid),
        .delay_err (delay_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the list of samples accepted since reset, newest last.
    typedef struct packed {
        logic        v;
        logic [15:0] d;
    } ent_t;

    ent_t hist[$];
    int   m_d   = INIT;
    bit   m_err = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            m_d   = INIT;
            m_err = 1'b0;
        end else if (ce) begin
            if (flush) foreach (hist[i]) hist[i].v = 1'b0;
            hist.push_back('{v: in_valid & ~flush, d: data});
            if (hist.size() > 64) void'(hist.pop_front());
            m_d = (int'(delay) > MAX) ? MAX : int'(delay);
            if (int'(delay) > MAX) m_err = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic        ev;
        logic [15:0] eo;
        ent_t        e;
        if (chk_en) begin
            if (m_d == 0) begin
                ev = in_valid;
                eo = in_valid ? data : 16'h0;
            end else if (hist.size() >= m_d) begin
                e  = hist[hist.size() - m_d];
                ev = e.v;
                eo = e.v ? e.d : 16'h0;
            end else begin
                ev = 1'b0;
                eo = 16'h0;
            end
            check("model_valid", 32'(out_valid), 32'(ev));
            check("model_outp", 32'(outp), 32'(eo));
            check("model_err", 32'(delay_err), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic iv, input logic [15:0] dd, input logic [DW-1:0] dl,
                       input logic c, input logic fl);
        in_valid = iv;
        data     = dd;
        delay    = dl;
        ce       = c;
        flush    = fl;
        tick();
    endtask

    function automatic logic [15:0] pat(input int s);
        return {8'(s + 1), 8'(s)};
    endfunction

    initial begin
        rst = 1'b1; ce = 1'b0; flush = 1'b0; in_valid = 1'b0; data = '0; delay = DW'(INIT);
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_outp", 32'(outp), 32'd0);
        check("rst_err", 32'(delay_err), 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Fixed delay 5
        for (int k = 0; k < 12; k++) begin
            drv(1'b1, pat(k), 5'd5, 1'b1, 1'b0);
            if (k == 3) check("t1_not_yet_valid", 32'(out_valid), 32'd0);
            if (k == 4) begin
                check("t1_first_valid", 32'(out_valid), 32'd1);
                check("t1_first_data", 32'(outp), 32'h0100);
            end
            if (k == 9) check("t1_data_k9", 32'(outp), 32'h0605);
        end

        // ce gating at delay 3; flush while ce=0 must be ignored
        for (int k = 0; k < 16; k++) begin
            drv(1'b1, pat(8'h20 + k), 5'd3, (k % 2) == 0, k == 5);
            if (k == 4) check("t2_first_data", 32'(outp), 32'h2120);
            if (k == 5) check("t2_hold_data", 32'(outp), 32'h2120);
            if (k == 6) begin
                check("t2_next_data", 32'(outp), 32'h2322);
                check("t2_flush_ignored", 32'(out_valid), 32'd1);
            end
        end

        // Delay change 8 -> 2 -> 8
        for (int k = 0; k < 24; k++) begin
            drv(1'b1, pat(8'h40 + k), (k >= 12 && k < 16) ? 5'd2 : 5'd8, 1'b1, 1'b0);
            if (k == 12) check("t3_skip_data", 32'(outp), 32'h4C4B);
            if (k == 16) begin
                check("t3_repeat_data", 32'(outp), 32'h4A49);
                check("t3_repeat_valid", 32'(out_valid), 32'd1);
            end
        end

        // Bypass and clamp
        drv(1'b1, pat(8'h60), 5'd0, 1'b1, 1'b0);
        data = 16'hBEEF;
        #1;
        check("t4_bypass_data", 32'(outp), 32'hBEEF);
        check("t4_bypass_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #1;
        check("t4_bypass_zero", 32'(outp), 32'd0);
        drv(1'b1, pat(8'h61), 5'd20, 1'b1, 1'b0);
        check("t4_err_set", 32'(delay_err), 32'd1);
        for (int k = 0; k < 6; k++) drv(1'b1, pat(8'h62 + k), 5'd4, 1'b1, 1'b0);
        check("t4_err_sticky", 32'(delay_err), 32'd1);

        // Flush at delay 4
        for (int k = 0; k < 8; k++) drv(1'b1, pat(8'h70 + k), 5'd4, 1'b1, 1'b0);
        drv(1'b1, pat(8'h78), 5'd4, 1'b1, 1'b1);
        check("t5_flush_valid0", 32'(out_valid), 32'd0);
        check("t5_flush_outp0", 32'(outp), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            drv(1'b1, pat(8'h78 + i), 5'd4, 1'b1, 1'b0);
            if (i < 4) check("t5_flushed_valid", 32'(out_valid), 32'd0);
            else begin
                check("t5_resume_valid", 32'(out_valid), 32'd1);
                check("t5_resume_data", 32'(outp), 32'h7A79);
            end
        end

        // Mid-stream reset at delay 6
        for (int k = 0; k < 10; k++) drv(1'b1, pat(8'h90 + k), 5'd6, 1'b1, 1'b0);
        rst = 1'b1;
        drv(1'b1, pat(8'h9A), 5'd6, 1'b1, 1'b0);
        rst = 1'b0;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_err", 32'(delay_err), 32'd0);
        drv(1'b1, pat(8'hA0), 5'(INIT), 1'b1, 1'b0);
        check("t6_first_valid", 32'(out_valid), 32'd1);
        check("t6_first_data", 32'(outp), 32'hA1A0);
        for (int k = 1; k < 12; k++) drv(1'b1, pat(8'hA0 + k), (k < 4) ? 5'(INIT) : 5'd6, 1'b1, 1'b0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
